// File: rtl/sequential_divider.sv
// Multi-cycle restoring divider: 8-bit dividend / 4-bit divisor, one quotient bit per clock.
// Define SEQUENTIAL_DIVIDER_DBZ_EN to short-circuit divide-by-zero and raise dbz.
module sequential_divider (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [7:0] a,
   input  logic [3:0] b,
   output logic [7:0] quot,
   output logic [3:0] rem,
   output logic       busy,
   output logic       done,
   output logic       dbz
);

   localparam int unsigned DVD_W = 8;
   localparam int unsigned DVS_W = 4;
   localparam int unsigned CNT_W = 3;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t             r_state;
   state_t             w_state_nxt;
   logic [DVD_W-1:0]   r_dvd;
   logic [DVS_W-1:0]   r_dvs;
   logic [DVS_W-1:0]   r_part;
   logic [CNT_W-1:0]   r_cnt;
   logic [DVD_W-1:0]   r_qacc;
   logic [DVD_W-1:0]   r_quot;
   logic [DVS_W-1:0]   r_rem;
   logic               r_busy;
   logic               r_done;

   logic               w_accept;
   logic               w_zero_dbz;
   logic               w_last;
   logic [DVS_W:0]     w_t;
   logic               w_ge;
   logic [DVS_W-1:0]   w_part_nxt;
   logic               w_load_run;
   logic               w_busy_nxt;
   logic               w_done_nxt;

   assign w_accept = start && (r_state != S_RUN);
   assign w_last   = (r_cnt == CNT_W'(DVD_W - 1));

`ifdef SEQUENTIAL_DIVIDER_DBZ_EN
   assign w_zero_dbz = (b == '0);
`else
   assign w_zero_dbz = 1'b0;
`endif

   // Restoring step; the top bit of r never feeds back, so only r[3:0] is stored.
   assign w_t        = {r_part, r_dvd[DVD_W-1]};
   assign w_ge       = (w_t >= {1'b0, r_dvs});
   assign w_part_nxt = w_ge ? DVS_W'(w_t - {1'b0, r_dvs}) : w_t[DVS_W-1:0];

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_nxt;
   end

   // Next-state logic
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (start) w_state_nxt = w_zero_dbz ? S_DONE : S_RUN;
         S_RUN:   if (w_last) w_state_nxt = S_DONE;
         S_DONE:  w_state_nxt = start ? (w_zero_dbz ? S_DONE : S_RUN) : S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Output decode; a result is loaded on the last step or on a short-circuited zero divisor
   always_comb begin
      w_load_run = (r_state == S_RUN) && w_last;
      w_busy_nxt = (w_state_nxt == S_RUN);
      w_done_nxt = w_load_run || (w_accept && w_zero_dbz);
   end

   // Datapath and registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_dvd  <= '0;
         r_dvs  <= '0;
         r_part <= '0;
         r_cnt  <= '0;
         r_qacc <= '0;
         r_quot <= '0;
         r_rem  <= '0;
         r_busy <= 1'b0;
         r_done <= 1'b0;
      end else begin
         r_busy <= w_busy_nxt;
         r_done <= w_done_nxt;
         if (w_accept) begin
            r_dvd  <= a;
            r_dvs  <= b;
            r_part <= '0;
            r_cnt  <= '0;
            r_qacc <= '0;
            if (w_zero_dbz) begin
               r_quot <= '1;
               r_rem  <= '0;
            end
         end else if (r_state == S_RUN) begin
            r_dvd  <= {r_dvd[DVD_W-2:0], 1'b0};
            r_part <= w_part_nxt;
            r_qacc <= {r_qacc[DVD_W-2:0], w_ge};
            r_cnt  <= CNT_W'(r_cnt + 1'b1);
            if (w_load_run) begin
               r_quot <= {r_qacc[DVD_W-2:0], w_ge};
               r_rem  <= w_part_nxt;
            end
         end
      end
   end

`ifdef SEQUENTIAL_DIVIDER_DBZ_EN
   logic r_dbz;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                          r_dbz <= 1'b0;
      else if (w_accept && w_zero_dbz)  r_dbz <= 1'b1;
      else if (w_load_run)              r_dbz <= 1'b0;
   end

   assign dbz = r_dbz;
`else
   assign dbz = 1'b0;
`endif

   assign quot = r_quot;
   assign rem  = r_rem;
   assign busy = r_busy;
   assign done = r_done;

endmodule

// File: tb/tb_sequential_divider.sv
// Directed and exhaustive checks of sequential_divider; expectations follow the build macro.
module tb_sequential_divider;

`ifdef SEQUENTIAL_DIVIDER_DBZ_EN
   localparam bit DBZ_BUILD = 1'b1;
`else
   localparam bit DBZ_BUILD = 1'b0;
`endif

   logic       clk;
   logic       rst;
   logic       start;
   logic [7:0] a;
   logic [3:0] b;
   logic [7:0] quot;
   logic [3:0] rem;
   logic       busy;
   logic       done;
   logic       dbz;

   int n_cmp = 0;
   int n_bad = 0;

   sequential_divider dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .a     (a),
      .b     (b),
      .quot  (quot),
      .rem   (rem),
      .busy  (busy),
      .done  (done),
      .dbz   (dbz)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Entered and left at 1 time unit after a rising edge. lat counts edges after the
   // accepting edge until done is seen; inject>=0 pulses start with other operands mid-run.
   task automatic run_div(input logic [7:0] ta, input logic [3:0] tb_, input logic [7:0] eq,
                          input logic [3:0] er, input logic edbz, input int elat,
                          input int inject, input string tag);
      int lat;
      int bcnt;
      a = ta;
      b = tb_;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      a = ~ta;
      b = ~tb_;
      lat  = 0;
      bcnt = 0;
      while (!done && lat < 20) begin
         if (busy) bcnt++;
         if (lat == inject) begin
            start = 1'b1;
            a = 8'hFF;
            b = 4'h1;
         end else begin
            start = 1'b0;
         end
         @(posedge clk); #1;
         lat++;
      end
      start = 1'b0;
      chk({tag, " latency"}, 32'(lat), 32'(elat));
      chk({tag, " busy_cycles"}, 32'(bcnt), 32'(elat));
      chk({tag, " quot"}, 32'(quot), 32'(eq));
      chk({tag, " rem"}, 32'(rem), 32'(er));
      chk({tag, " dbz"}, 32'(dbz), 32'(edbz));
      chk({tag, " busy_at_done"}, 32'(busy), 32'(0));
      @(posedge clk); #1;
      chk({tag, " done_drop"}, 32'(done), 32'(0));
   endtask

   initial begin : stim
      int d;
      logic [7:0] eq;
      logic [3:0] er;
      logic       zd;

      rst   = 1'b1;
      start = 1'b0;
      a     = 8'h00;
      b     = 4'h0;
      #12;
      chk("reset quot", 32'(quot), 32'(0));
      chk("reset rem", 32'(rem), 32'(0));
      chk("reset busy", 32'(busy), 32'(0));
      chk("reset done", 32'(done), 32'(0));
      chk("reset dbz", 32'(dbz), 32'(0));
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;

      // Directed vectors: 100/7=14 r2, 255/15=17 r0, 255/1, 5/9, 0/3
      run_div(8'h64, 4'h7, 8'h0E, 4'h2, 1'b0, 8, -1, "64/7");
      run_div(8'hFF, 4'hF, 8'h11, 4'h0, 1'b0, 8, -1, "FF/F");
      run_div(8'hFF, 4'h1, 8'hFF, 4'h0, 1'b0, 8, -1, "FF/1");
      run_div(8'h05, 4'h9, 8'h00, 4'h5, 1'b0, 8, -1, "05/9");
      run_div(8'h00, 4'h3, 8'h00, 4'h0, 1'b0, 8, -1, "00/3");

      // Zero divisor: short-circuit with dbz, or full loop returning a[3:0]
      if (DBZ_BUILD) run_div(8'h5A, 4'h0, 8'hFF, 4'h0, 1'b1, 0, -1, "5A/0 dbz");
      else           run_div(8'h5A, 4'h0, 8'hFF, 4'hA, 1'b0, 8, -1, "5A/0 loop");
      run_div(8'h64, 4'h7, 8'h0E, 4'h2, 1'b0, 8, -1, "dbz cleared");

      // start mid-run is ignored
      run_div(8'h64, 4'h7, 8'h0E, 4'h2, 1'b0, 8, 3, "midrun start");

      // Back-to-back: start held in DONE is accepted, 81/9=9 r0
      a = 8'hFF; b = 4'hF; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      d = 0;
      while (!done && d < 20) begin
         @(posedge clk); #1;
         d++;
      end
      chk("b2b first latency", 32'(d), 32'(8));
      chk("b2b first quot", 32'(quot), 32'(8'h11));
      a = 8'h51; b = 4'h9; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      chk("b2b busy_again", 32'(busy), 32'(1));
      chk("b2b done_low", 32'(done), 32'(0));
      d = 1;
      while (!done && d < 20) begin
         @(posedge clk); #1;
         d++;
      end
      chk("b2b done_spacing", 32'(d), 32'(9));
      chk("b2b quot", 32'(quot), 32'(8'h09));
      chk("b2b rem", 32'(rem), 32'(4'h0));
      @(posedge clk); #1;
      chk("b2b done_drop", 32'(done), 32'(0));

      // Reset at step 4 of 200/5 clears everything at once
      a = 8'hC8; b = 4'h5; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (4) begin
         @(posedge clk); #1;
      end
      chk("pre-rst busy", 32'(busy), 32'(1));
      rst = 1'b1;
      #1;
      chk("rst quot", 32'(quot), 32'(0));
      chk("rst rem", 32'(rem), 32'(0));
      chk("rst busy", 32'(busy), 32'(0));
      chk("rst done", 32'(done), 32'(0));
      chk("rst dbz", 32'(dbz), 32'(0));
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         chk("post-rst idle busy", 32'(busy), 32'(0));
         chk("post-rst idle done", 32'(done), 32'(0));
      end
      run_div(8'hC8, 4'h5, 8'h28, 4'h0, 1'b0, 8, -1, "C8/5 after rst");

      // Exhaustive operand sweep against a division model
      for (int i = 0; i < 256; i++) begin
         for (int j = 0; j < 16; j++) begin
            zd = (j == 0);
            if (zd) begin
               eq = 8'hFF;
               er = DBZ_BUILD ? 4'h0 : 4'(i);
            end else begin
               eq = 8'(i / j);
               er = 4'(i % j);
            end
            run_div(8'(i), 4'(j), eq, er, zd && DBZ_BUILD, (zd && DBZ_BUILD) ? 0 : 8, -1,
                    $sformatf("sweep %0h/%0h", i, j));
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
